// File: rtl/mux41_scan_ctrl.sv
// Round-robin scan controller that drives the select of a 4:1 word mux and hands the sampled word downstream.
// Optional HOLD timeout with a drop pulse is built only when MUX41_SCAN_TIMEOUT_EN is defined.
module mux41_scan_ctrl #(
  parameter int WIDTH          = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  output logic [1:0]       sel,
  input  logic [WIDTH-1:0] mux_y,
  output logic [3:0]       grant,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_ch,
  output logic             drop
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_last;
  logic [1:0] w_pick;
  logic       w_found;
  logic       w_xfer;
  logic       w_timeout;

  // Search from the candidate furthest from last back toward last+1, so the nearest requester wins.
  always_comb begin
    logic [1:0] idx;
    idx     = r_last;
    w_pick  = r_last;
    w_found = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      idx = r_last + 2'(k);
      if (req[idx]) begin
        w_pick  = idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_xfer = (r_state == HOLD) && out_valid && out_ready;

`ifdef MUX41_SCAN_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  // The edge that would bring the stall count to TIMEOUT_CYCLES gives up the word; a ready on that edge wins.
  assign w_timeout = (r_state == HOLD) && !out_ready &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      drop  <= 1'b0;
    end else begin
      drop <= w_timeout;
      if (r_state == CAPTURE) begin
        r_cnt <= '0;
      end else if ((r_state == HOLD) && !out_ready) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign drop      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_found) w_next = CAPTURE;
      CAPTURE: w_next = HOLD;
      HOLD:    if (w_xfer || w_timeout) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Capture trusts that sel has been stable for a full cycle, so mux_y is settled by then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel       <= 2'd0;
      grant     <= 4'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= 2'd0;
      r_last    <= 2'd3;
    end else begin
      grant <= 4'd0;
      case (r_state)
        IDLE: begin
          if (w_found) sel <= w_pick;
        end
        CAPTURE: begin
          out_data  <= mux_y;
          out_ch    <= sel;
          out_valid <= 1'b1;
          grant     <= 4'b0001 << sel;
        end
        HOLD: begin
          if (w_xfer || w_timeout) begin
            out_valid <= 1'b0;
            r_last    <= out_ch;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux41_scan_ctrl.sv
// Self-checking bench for mux41_scan_ctrl: a bench-side 4:1 mux feeds mux_y, and a transaction-level
// round-robin model predicts which channel and word every service must produce.
module tb_mux41_scan_ctrl;

  localparam int WIDTH = 4;
  localparam int TO    = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req;
  logic [1:0]       sel;
  logic [WIDTH-1:0] muxY;
  logic [3:0]       grant;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] outData;
  logic [1:0]       outCh;
  logic             drop;

  logic [WIDTH-1:0] w [4];

  int passCount  = 0;
  int checkCount = 0;
  int modelLast  = 3;

  mux41_scan_ctrl #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .sel       (sel),
    .mux_y     (muxY),
    .grant     (grant),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_data  (outData),
    .out_ch    (outCh),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  assign muxY = w[sel];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic rdy);
    req      = r;
    outReady = rdy;
  endtask

  task automatic randomizeWords;
    for (int i = 0; i < 4; i++) w[i] = WIDTH'($urandom);
  endtask

  function automatic int pickNext(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return last;
  endfunction

  // One full service: arbitration edge, capture edge, holdCycles stalled edges, then the transfer edge.
  task automatic serveWord(input logic [3:0] r, input int holdCycles, input string tag);
    int               expCh;
    logic [WIDTH-1:0] expData;
    expCh = pickNext(r, modelLast);
    applyStimulus(r, 1'b0);
    tick;
    checkOutput({tag, ":sel"}, 32'(sel), 32'(expCh));
    checkOutput({tag, ":validIdle"}, 32'(outValid), 32'd0);
    checkOutput({tag, ":dropIdle"}, 32'(drop), 32'd0);
    expData = w[expCh];
    applyStimulus(4'($urandom), holdCycles == 0);
    tick;
    checkOutput({tag, ":valid"}, 32'(outValid), 32'd1);
    checkOutput({tag, ":data"}, 32'(outData), 32'(expData));
    checkOutput({tag, ":ch"}, 32'(outCh), 32'(expCh));
    checkOutput({tag, ":grant"}, 32'(grant), 32'(1 << expCh));
    for (int h = 0; h < holdCycles; h++) begin
      randomizeWords();
      if (h == 0) for (int i = 0; i < 4; i++) w[i] = '1;
      tick;
      checkOutput({tag, ":holdValid"}, 32'(outValid), 32'd1);
      checkOutput({tag, ":holdData"}, 32'(outData), 32'(expData));
      checkOutput({tag, ":holdCh"}, 32'(outCh), 32'(expCh));
      checkOutput({tag, ":holdSel"}, 32'(sel), 32'(expCh));
      checkOutput({tag, ":holdGrant"}, 32'(grant), 32'd0);
      checkOutput({tag, ":holdDrop"}, 32'(drop), 32'd0);
    end
    outReady = 1'b1;
    tick;
    checkOutput({tag, ":xferValid"}, 32'(outValid), 32'd0);
    checkOutput({tag, ":xferGrant"}, 32'(grant), 32'd0);
    checkOutput({tag, ":xferDrop"}, 32'(drop), 32'd0);
    modelLast = expCh;
    outReady  = 1'b0;
  endtask

`ifdef MUX41_SCAN_TIMEOUT_EN
  task automatic timeoutWord(input logic [3:0] r, input logic readyOnLast, input string tag);
    int expCh;
    expCh = pickNext(r, modelLast);
    applyStimulus(r, 1'b0);
    tick;
    tick;
    checkOutput({tag, ":valid"}, 32'(outValid), 32'd1);
    checkOutput({tag, ":ch"}, 32'(outCh), 32'(expCh));
    for (int h = 0; h < TO - 1; h++) begin
      tick;
      checkOutput({tag, ":waitValid"}, 32'(outValid), 32'd1);
      checkOutput({tag, ":waitDrop"}, 32'(drop), 32'd0);
    end
    outReady = readyOnLast;
    tick;
    checkOutput({tag, ":endValid"}, 32'(outValid), 32'd0);
    checkOutput({tag, ":endDrop"}, 32'(drop), 32'(!readyOnLast));
    modelLast = expCh;
    outReady  = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    applyStimulus(4'd0, 1'b0);
    randomizeWords();
    tick;
    checkOutput("rst:sel", 32'(sel), 32'd0);
    checkOutput("rst:grant", 32'(grant), 32'd0);
    checkOutput("rst:valid", 32'(outValid), 32'd0);
    checkOutput("rst:data", 32'(outData), 32'd0);
    checkOutput("rst:ch", 32'(outCh), 32'd0);
    checkOutput("rst:drop", 32'(drop), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    w[2] = 4'b1010;
    serveWord(4'b0100, 0, "single");

    applyStimulus(4'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput("idle:valid", 32'(outValid), 32'd0);
      checkOutput("idle:sel", 32'(sel), 32'(modelLast));
    end

    modelLast = 3;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) w[i] = WIDTH'(i + 1);
    for (int n = 0; n < 5; n++) serveWord(4'b1111, 0, "fair");

    serveWord(4'b0010, 5, "backpressure");

    serveWord(4'b1000, 1, "wrapPre");
    serveWord(4'b1001, 0, "wrap0");
    serveWord(4'b1001, 0, "wrap3");

    applyStimulus(4'b0010, 1'b0);
    tick;
    tick;
    checkOutput("midHold:valid", 32'(outValid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midHold:sel", 32'(sel), 32'd0);
    checkOutput("midHold:valid", 32'(outValid), 32'd0);
    checkOutput("midHold:data", 32'(outData), 32'd0);
    checkOutput("midHold:ch", 32'(outCh), 32'd0);
    checkOutput("midHold:grant", 32'(grant), 32'd0);
    checkOutput("midHold:drop", 32'(drop), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    modelLast = 3;
    serveWord(4'b1111, 0, "afterRst");

    for (int n = 0; n < 20; n++) begin
      randomizeWords();
      serveWord(4'($urandom_range(1, 15)), $urandom_range(0, 6), "rand");
    end

`ifdef MUX41_SCAN_TIMEOUT_EN
    timeoutWord(4'b1111, 1'b0, "timeoutDrop");
    serveWord(4'b1111, 0, "afterDrop");
    timeoutWord(4'b1111, 1'b1, "timeoutXfer");
    serveWord(4'b1111, 0, "afterXfer");
`else
    serveWord(4'b1111, 20, "noTimeout");
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mux41_scan_ctrl.md
Name: mux41_scan_ctrl

Overview:
- Round-robin scan controller that sits directly upstream of the 4:1 word multiplexer.
- Arbitrates four per-channel request lines and drives the mux's 2-bit select.
- Samples the returned mux output and presents it downstream as {channel, data} with a valid/ready handshake.
- Gives fair, back-pressure-aware access to the four mux inputs.

Parameters:
- WIDTH, 4, bit width of each mux data word (mux_y, out_data).
- TIMEOUT_CYCLES, 16, HOLD cycles without out_ready before the word is dropped (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  4  per-channel request levels; bit i = channel i has data on mux input wi.
- sel  output  2  registered select driven to the mux S input.
- mux_y  input  WIDTH  mux output Y, returned combinationally.
- grant  output  4  one-hot, one-cycle pulse marking the captured channel; the source may clear its req.
- out_valid  output  1  out_data/out_ch hold a word.
- out_ready  input  1  downstream accepts the word.
- out_data  output  WIDTH  captured mux word.
- out_ch  output  2  channel the word came from.
- drop  output  1  one-cycle pulse when a word is discarded on timeout; tied 0 without the optional feature.

Behaviour:
- Reset (rst_n low, asynchronous) forces: state=IDLE, sel=0, grant=0, out_valid=0, out_data=0, out_ch=0, drop=0, last pointer=3 (channel 0 has first priority), timeout counter=0.
- Reset asserted in any state, including mid-HOLD, discards the held word immediately.
- FSM has three states: IDLE, CAPTURE, HOLD.
- IDLE:
  - If req != 0, pick the first set bit searching last+1, last+2, ... modulo 4 (wrap 3->0).
  - Register sel <= chosen channel and move to CAPTURE.
  - If req == 0, stay in IDLE; sel holds its previous value.
- CAPTURE: lasts exactly one cycle; sel has been stable for a full cycle, so the mux has settled.
  - At the edge: out_data <= mux_y, out_ch <= sel, out_valid <= 1, grant <= one-hot(sel) for one cycle, move to HOLD.
  - The capture is committed: a req drop during CAPTURE does not abort it.
- HOLD:
  - out_valid, out_data, out_ch and sel stay stable.
  - A transfer happens on any edge where out_valid && out_ready. At that edge: out_valid <= 0, last <= out_ch, move to IDLE.
  - out_ready high in the first HOLD cycle transfers on that edge.
- Latency and throughput:
  - req seen at edge N -> sel valid after edge N.
  - out_valid and grant high after edge N+1.
  - Minimum 3 cycles per word (IDLE, CAPTURE, HOLD).
- Only one word is ever in flight. req changes during CAPTURE or HOLD affect only the next arbitration.
- Fairness: after channel c is served, c has the lowest priority. With continuous requests, all four channels are served in order 0,1,2,3,0,...
- X on req is not tolerated; the bench must drive it.

Optional Feature:
- Macro: MUX41_SCAN_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to HOLD and increments each HOLD cycle with out_ready low.
  - When it reaches TIMEOUT_CYCLES: out_valid <= 0, drop pulses one cycle, last <= out_ch, move to IDLE.
  - If out_ready is high on the same cycle the count reaches TIMEOUT_CYCLES, the transfer wins and drop stays 0.
- Undefined: no counter is built, HOLD waits indefinitely, drop is constant 0.

Test Plan:
- Reset mid-HOLD with out_valid=1: rst_n=0 for one cycle -> every output 0 immediately, with no clock edge required; first request afterwards is served from channel 0.
- Single request: req=4'b0100, bench mux w2=4'b1010, out_ready=1 -> sel=2 one edge after req is seen; next edge out_valid=1, out_data=4'b1010, out_ch=2, grant=4'b0100 for one cycle; transfer on the following edge.
- Fairness: req=4'b1111 held, out_ready=1, w0..w3 = 1,2,3,4 -> out_ch sequence 0,1,2,3,0 and out_data 1,2,3,4,1, one word per 3 cycles.
- Backpressure: out_ready=0 for 5 cycles after out_valid, with mux_y changed to 4'b1111 -> out_data, out_ch and sel unchanged; transfer on the first out_ready=1 edge; no new grant during HOLD.
- Wrap-around priority: after channel 3 is served, req=4'b1001 -> channel 0 is chosen next; then, with req still 4'b1001, channel 3.
- With MUX41_SCAN_TIMEOUT_EN, TIMEOUT_CYCLES=16: out_ready=0 held -> drop=1 one cycle, out_valid=0 after 16 HOLD cycles, next grant goes to the next channel.
- Repeat with out_ready=1 on cycle 16 -> transfer occurs and drop stays 0.
